// File: rtl/io_arb_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | io_arb_pkg: shared types and helpers for the stream arbiters           |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
package io_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // A one-port index would otherwise collapse to a zero-width vector.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_rr_pick.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | io_rr_pick: combinational rotate-and-find-first request picker         |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module io_rr_pick
    import io_arb_pkg::*;
#(
    parameter int N_PORTS  = 4,
    parameter int ID_WIDTH = clog2_min1(N_PORTS)
) (
    input  logic [N_PORTS-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [ID_WIDTH-1:0] gnt_id,
    output logic                gnt_valid
);

    always_comb begin
        int idx;
        idx       = 0;
        gnt_id    = '0;
        gnt_valid = 1'b0;
        // Walk the ports in priority order starting at ptr, wrapping at N_PORTS.
        for (int i = 0; i < N_PORTS; i++) begin
            idx = (int'(ptr) + i) % N_PORTS;
            for (int j = 0; j < N_PORTS; j++) begin
                if ((j == idx) && req[j] && !gnt_valid) begin
                    gnt_valid = 1'b1;
                    gnt_id    = ID_WIDTH'(j);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/io_stream_rr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | io_stream_rr_arbiter: packet-locked round-robin stream arbiter         |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module io_stream_rr_arbiter
    import io_arb_pkg::*;
#(
    parameter int N_PORTS    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BEATS  = 16,
    parameter int ID_WIDTH   = clog2_min1(N_PORTS)
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          clr_i,
    input  logic [N_PORTS-1:0]            valid_i,
    input  logic [N_PORTS*DATA_WIDTH-1:0] data_i,
    input  logic [N_PORTS-1:0]            last_i,
    output logic [N_PORTS-1:0]            ready_o,
    output logic                          valid_o,
    output logic [DATA_WIDTH-1:0]         data_o,
    output logic                          last_o,
    output logic [ID_WIDTH-1:0]           id_o,
    input  logic                          ready_i,
    output logic                          busy_o
);

    localparam int                  CNT_W     = clog2_min1(MAX_BEATS + 1);
    localparam int                  FORCE_AT  = (MAX_BEATS == 0) ? 0 : MAX_BEATS - 1;
    localparam logic [ID_WIDTH-1:0] LAST_PORT = ID_WIDTH'(N_PORTS - 1);

    arb_state_e          state_q, state_d;
    logic [ID_WIDTH-1:0] grant_q, grant_d;
    logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;

    logic                  pick_valid;
    logic [ID_WIDTH-1:0]   pick_id;
    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  force_end;
    logic                  beat;

    io_rr_pick #(
        .N_PORTS  (N_PORTS),
        .ID_WIDTH (ID_WIDTH)
    ) u_pick (
        .req       (valid_i),
        .ptr       (rr_ptr_q),
        .gnt_id    (pick_id),
        .gnt_valid (pick_valid)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            if (grant_q == ID_WIDTH'(p)) begin
                sel_valid = valid_i[p];
                sel_last  = last_i[p];
                sel_data  = data_i[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign force_end = (MAX_BEATS != 0) && (beat_cnt_q == CNT_W'(FORCE_AT));
    assign beat      = valid_o && ready_i;

    // State register
    always_ff @(posedge clk_i) begin
        if (!rstn_i || clr_i) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d    = pick_id;
                    beat_cnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (beat) begin
                    if (MAX_BEATS != 0) begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                    // last_o already folds in the forced release.
                    if (last_o) begin
                        state_d    = IDLE;
                        beat_cnt_d = '0;
                        rr_ptr_d   = (grant_q == LAST_PORT) ? '0 : grant_q + ID_WIDTH'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        valid_o = 1'b0;
        data_o  = '0;
        last_o  = 1'b0;
        ready_o = '0;
        if (state_q == GRANT) begin
            valid_o = sel_valid;
            for (int p = 0; p < N_PORTS; p++) begin
                ready_o[p] = (grant_q == ID_WIDTH'(p)) && ready_i;
            end
            if (sel_valid) begin
                data_o = sel_data;
                last_o = sel_last || force_end;
            end
        end
    end

    assign id_o   = grant_q;
    assign busy_o = (state_q == GRANT);

endmodule
`default_nettype wire

// File: tb/tb_io_stream_rr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_io_stream_rr_arbiter: directed self-checking bench, MAX_BEATS = 4   |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_io_stream_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rstn;
    logic          clr;
    logic [N-1:0]  valid_i;
    logic [N*DW-1:0] data_i;
    logic [N-1:0]  last_i;
    logic [N-1:0]  ready_o;
    logic          valid_o;
    logic [DW-1:0] data_o;
    logic          last_o;
    logic [1:0]    id_o;
    logic          ready_i;
    logic          busy_o;

    int total = 0;
    int bad   = 0;

    // {busy, id, valid, last, ready[3:0], data}
    logic [40:0] obs;
    assign obs = {busy_o, id_o, valid_o, last_o, ready_o, data_o};

    io_stream_rr_arbiter #(
        .N_PORTS    (N),
        .DATA_WIDTH (DW),
        .MAX_BEATS  (4)
    ) dut (
        .clk_i   (clk),
        .rstn_i  (rstn),
        .clr_i   (clr),
        .valid_i (valid_i),
        .data_i  (data_i),
        .last_i  (last_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .data_o  (data_o),
        .last_o  (last_o),
        .id_o    (id_o),
        .ready_i (ready_i),
        .busy_o  (busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [40:0] ev(input logic b, input logic [1:0] id, input logic v,
                                       input logic l, input logic [3:0] r, input logic [31:0] d);
        return {b, id, v, l, r, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn    = 1'b0;
        clr     = 1'b0;
        valid_i = '0;
        last_i  = '0;
        data_i  = '0;
        ready_i = 1'b1;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        logic [40:0] e;
        rstn    = 1'b0;
        clr     = 1'b0;
        valid_i = 4'b1111;
        last_i  = 4'b1111;
        ready_i = 1'b1;
        for (int p = 0; p < N; p++) data_i[p*DW +: DW] = 32'h5A00_0000 + p;
        tick(); tick(); tick();
        #1;
        e = ev(1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 32'h0);
        total++;
        if (obs !== e) begin bad++; $display("FAIL reset_hold got=%h want=%h", obs, e); end
        rstn = 1'b1;
        #1;
        total++;
        if (obs !== e) begin bad++; $display("FAIL reset_release_idle got=%h want=%h", obs, e); end
        tick();
        #1;
        e = ev(1'b1, 2'd0, 1'b1, 1'b1, 4'b0001, 32'h5A00_0000);
        total++;
        if (obs !== e) begin bad++; $display("FAIL reset_first_grant got=%h want=%h", obs, e); end
    endtask

    task automatic test_fairness();
        logic [40:0] e;
        logic [1:0]  exp_id [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        valid_i = 4'b1111;
        last_i  = 4'b1111;
        for (int p = 0; p < N; p++) data_i[p*DW +: DW] = 32'hA0 + p;
        for (int k = 0; k < 5; k++) begin
            tick();
            #1;
            e = ev(1'b1, exp_id[k], 1'b1, 1'b1, 4'b0001 << exp_id[k], 32'hA0 + exp_id[k]);
            total++;
            if (obs !== e) begin bad++; $display("FAIL fair_grant%0d got=%h want=%h", k, obs, e); end
            tick();
            #1;
            e = ev(1'b0, exp_id[k], 1'b0, 1'b0, 4'b0000, 32'h0);
            total++;
            if (obs !== e) begin bad++; $display("FAIL fair_gap%0d got=%h want=%h", k, obs, e); end
        end
        valid_i = '0;
    endtask

    task automatic test_packet_lock();
        logic [40:0] e;
        do_reset();
        valid_i = 4'b0010;
        last_i  = 4'b0010;
        data_i[1*DW +: DW] = 32'h11;
        tick(); tick();
        valid_i = 4'b0110;
        data_i[2*DW +: DW] = 32'hB1;
        tick();
        #1;
        e = ev(1'b1, 2'd2, 1'b1, 1'b0, 4'b0100, 32'hB1);
        total++;
        if (obs !== e) begin bad++; $display("FAIL lock_beat1 got=%h want=%h", obs, e); end
        tick();
        data_i[2*DW +: DW] = 32'hB2;
        #1;
        e = ev(1'b1, 2'd2, 1'b1, 1'b0, 4'b0100, 32'hB2);
        total++;
        if (obs !== e) begin bad++; $display("FAIL lock_beat2 got=%h want=%h", obs, e); end
        tick();
        valid_i[2] = 1'b0;
        #1;
        e = ev(1'b1, 2'd2, 1'b0, 1'b0, 4'b0100, 32'h0);
        total++;
        if (obs !== e) begin bad++; $display("FAIL lock_stall got=%h want=%h", obs, e); end
        tick();
        valid_i[2] = 1'b1;
        last_i[2]  = 1'b1;
        data_i[2*DW +: DW] = 32'hB3;
        #1;
        e = ev(1'b1, 2'd2, 1'b1, 1'b1, 4'b0100, 32'hB3);
        total++;
        if (obs !== e) begin bad++; $display("FAIL lock_beat3 got=%h want=%h", obs, e); end
        tick();
        valid_i[2] = 1'b0;
        last_i[2]  = 1'b0;
        #1;
        e = ev(1'b0, 2'd2, 1'b0, 1'b0, 4'b0000, 32'h0);
        total++;
        if (obs !== e) begin bad++; $display("FAIL lock_gap got=%h want=%h", obs, e); end
        tick();
        #1;
        e = ev(1'b1, 2'd1, 1'b1, 1'b1, 4'b0010, 32'h11);
        total++;
        if (obs !== e) begin bad++; $display("FAIL lock_next_port1 got=%h want=%h", obs, e); end
        valid_i = '0;
    endtask

    task automatic test_backpressure();
        logic [40:0] e;
        do_reset();
        valid_i = 4'b1000;
        data_i[3*DW +: DW] = 32'hC1;
        data_i[0*DW +: DW] = 32'hC0;
        tick();
        #1;
        e = ev(1'b1, 2'd3, 1'b1, 1'b0, 4'b1000, 32'hC1);
        total++;
        if (obs !== e) begin bad++; $display("FAIL bp_beat1 got=%h want=%h", obs, e); end
        tick();
        data_i[3*DW +: DW] = 32'hC2;
        ready_i = 1'b0;
        for (int s = 0; s < 5; s++) begin
            #1;
            e = ev(1'b1, 2'd3, 1'b1, 1'b0, 4'b0000, 32'hC2);
            total++;
            if (obs !== e) begin bad++; $display("FAIL bp_stall%0d got=%h want=%h", s, obs, e); end
            tick();
        end
        ready_i = 1'b1;
        #1;
        e = ev(1'b1, 2'd3, 1'b1, 1'b0, 4'b1000, 32'hC2);
        total++;
        if (obs !== e) begin bad++; $display("FAIL bp_beat2 got=%h want=%h", obs, e); end
        tick();
        data_i[3*DW +: DW] = 32'hC3;
        #1;
        e = ev(1'b1, 2'd3, 1'b1, 1'b0, 4'b1000, 32'hC3);
        total++;
        if (obs !== e) begin bad++; $display("FAIL bp_beat3 got=%h want=%h", obs, e); end
        tick();
        data_i[3*DW +: DW] = 32'hC4;
        #1;
        e = ev(1'b1, 2'd3, 1'b1, 1'b1, 4'b1000, 32'hC4);
        total++;
        if (obs !== e) begin bad++; $display("FAIL bp_beat4_forced got=%h want=%h", obs, e); end
        tick();
        valid_i = 4'b1001;
        tick();
        #1;
        e = ev(1'b1, 2'd0, 1'b1, 1'b0, 4'b0001, 32'hC0);
        total++;
        if (obs !== e) begin bad++; $display("FAIL bp_wrap_to_0 got=%h want=%h", obs, e); end
        valid_i = '0;
    endtask

    task automatic test_forced_release();
        logic [40:0] e;
        do_reset();
        valid_i = 4'b0010;
        data_i[2*DW +: DW] = 32'hF2;
        tick();
        for (int b = 1; b <= 4; b++) begin
            data_i[1*DW +: DW] = 32'hD0 + b;
            #1;
            e = ev(1'b1, 2'd1, 1'b1, (b == 4), 4'b0010, 32'hD0 + b);
            total++;
            if (obs !== e) begin bad++; $display("FAIL force_beat%0d got=%h want=%h", b, obs, e); end
            tick();
        end
        valid_i = 4'b0110;
        #1;
        total++;
        if (busy_o !== 1'b0) begin bad++; $display("FAIL force_idle busy got=%b want=0", busy_o); end
        tick();
        #1;
        e = ev(1'b1, 2'd2, 1'b1, 1'b0, 4'b0100, 32'hF2);
        total++;
        if (obs !== e) begin bad++; $display("FAIL force_rr_next got=%h want=%h", obs, e); end
        valid_i = '0;
    endtask

    task automatic test_clear();
        logic [40:0] e;
        do_reset();
        valid_i = 4'b0010;
        last_i  = 4'b0010;
        tick(); tick();
        valid_i = 4'b0100;
        last_i  = 4'b0000;
        data_i[2*DW +: DW] = 32'hE1;
        data_i[3*DW +: DW] = 32'hE3;
        tick();
        #1;
        e = ev(1'b1, 2'd2, 1'b1, 1'b0, 4'b0100, 32'hE1);
        total++;
        if (obs !== e) begin bad++; $display("FAIL clr_beat1 got=%h want=%h", obs, e); end
        tick();
        data_i[2*DW +: DW] = 32'hE2;
        clr = 1'b1;
        tick();
        clr     = 1'b0;
        valid_i = 4'b1000;
        #1;
        e = ev(1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 32'h0);
        total++;
        if (obs !== e) begin bad++; $display("FAIL clr_idle got=%h want=%h", obs, e); end
        tick();
        #1;
        e = ev(1'b1, 2'd3, 1'b1, 1'b0, 4'b1000, 32'hE3);
        total++;
        if (obs !== e) begin bad++; $display("FAIL clr_regrant3 got=%h want=%h", obs, e); end
        valid_i = '0;
    endtask

    initial begin
        rstn    = 1'b0;
        clr     = 1'b0;
        valid_i = '0;
        last_i  = '0;
        data_i  = '0;
        ready_i = 1'b0;
        test_reset();
        test_fairness();
        test_packet_lock();
        test_backpressure();
        test_forced_release();
        test_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
